alu_ctrl_issue: RTL and testbench

ID/EX-stage ALU control issuer. It decodes the RISC-V opcode, funct3 and funct7 fields into the 3-bit ALU operation code and registers the result into the EX stage, together with the operand-select and writeback controls. The ALU consumes this code directly. The block also sequences multi-cycle multiplies: it holds the issued mul code stable and back-pressures the front end until the multiplier latency has elapsed.

---
 rtl/alu_ctrl_issue.sv | 180 ++++++++++++++++++
 tb/tb_alu_ctrl_issue.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/alu_ctrl_issue.sv
// ID/EX ALU control issuer: decodes opcode/funct3/funct7 into a 3-bit ALU op and registers it, 1-cycle latency.
// Multi-cycle muls hold the EX outputs and raise busy_o for MUL_LAT-1 cycles; flush aborts, stall freezes.
module alu_ctrl_issue #(
    parameter int MUL_LAT = 3,
    parameter int CNT_W   = 4
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       valid_i,
    input  logic [6:0] opcode_i,
    input  logic [2:0] funct3_i,
    input  logic [6:0] funct7_i,
    input  logic       stall_i,
    input  logic       flush_i,
    output logic [2:0] ALUCtrl_o,
    output logic       ALUSrc_o,
    output logic       RegWrite_o,
    output logic       valid_o,
    output logic       busy_o,
    output logic       illegal_o
);

    localparam logic [2:0] OP_AND = 3'b000;
    localparam logic [2:0] OP_XOR = 3'b001;
    localparam logic [2:0] OP_SLL = 3'b010;
    localparam logic [2:0] OP_SUB = 3'b011;
    localparam logic [2:0] OP_MUL = 3'b100;
    localparam logic [2:0] OP_ADD = 3'b101;
    localparam logic [2:0] OP_SRA = 3'b110;

    localparam logic [6:0] OPC_R    = 7'b0110011;
    localparam logic [6:0] OPC_I    = 7'b0010011;
    localparam logic [6:0] OPC_LW   = 7'b0000011;
    localparam logic [6:0] OPC_SW   = 7'b0100011;
    localparam logic [6:0] OPC_BEQ  = 7'b1100011;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;
    localparam logic [6:0] F7_MUL  = 7'b0000001;

    localparam logic [CNT_W-1:0] MUL_WAIT_INIT = CNT_W'(MUL_LAT - 1);

    typedef enum logic {
        RUN      = 1'b0,
        MUL_WAIT = 1'b1
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] cnt;

    logic       dec_legal;
    logic [2:0] dec_code;
    logic       dec_src;
    logic       dec_wr;
    logic       dec_mul;

    always_comb begin
        dec_legal = 1'b0;
        dec_code  = OP_AND;
        dec_src   = 1'b0;
        dec_wr    = 1'b0;
        case (opcode_i)
            OPC_R: begin
                dec_src = 1'b0;
                dec_wr  = 1'b1;
                if (funct7_i == F7_BASE) begin
                    case (funct3_i)
                        3'b111: begin dec_code = OP_AND; dec_legal = 1'b1; end
                        3'b100: begin dec_code = OP_XOR; dec_legal = 1'b1; end
                        3'b001: begin dec_code = OP_SLL; dec_legal = 1'b1; end
                        3'b000: begin dec_code = OP_ADD; dec_legal = 1'b1; end
                        default: dec_legal = 1'b0;
                    endcase
                end else if (funct7_i == F7_ALT && funct3_i == 3'b000) begin
                    dec_code  = OP_SUB;
                    dec_legal = 1'b1;
                end else if (funct7_i == F7_MUL && funct3_i == 3'b000) begin
                    dec_code  = OP_MUL;
                    dec_legal = 1'b1;
                end
            end
            OPC_I: begin
                dec_src = 1'b1;
                dec_wr  = 1'b1;
                if (funct3_i == 3'b000) begin
                    dec_code  = OP_ADD;
                    dec_legal = 1'b1;
                end else if (funct3_i == 3'b101 && funct7_i == F7_ALT) begin
                    dec_code  = OP_SRA;
                    dec_legal = 1'b1;
                end
            end
            OPC_LW: begin
                dec_code  = OP_ADD;
                dec_src   = 1'b1;
                dec_wr    = 1'b1;
                dec_legal = (funct3_i == 3'b010);
            end
            OPC_SW: begin
                dec_code  = OP_ADD;
                dec_src   = 1'b1;
                dec_wr    = 1'b0;
                dec_legal = (funct3_i == 3'b010);
            end
            OPC_BEQ: begin
                dec_code  = OP_SUB;
                dec_src   = 1'b0;
                dec_wr    = 1'b0;
                dec_legal = (funct3_i == 3'b000);
            end
            default: dec_legal = 1'b0;
        endcase
    end

    assign dec_mul = (dec_code == OP_MUL);

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state      <= RUN;
            cnt        <= '0;
            ALUCtrl_o  <= OP_AND;
            ALUSrc_o   <= 1'b0;
            RegWrite_o <= 1'b0;
            valid_o    <= 1'b0;
            busy_o     <= 1'b0;
            illegal_o  <= 1'b0;
        end else begin
            illegal_o <= 1'b0;
            case (state)
                RUN: begin
                    if (flush_i) begin
                        valid_o    <= 1'b0;
                        RegWrite_o <= 1'b0;
                    end else if (stall_i) begin
                        valid_o <= valid_o;
                    end else if (valid_i && dec_legal) begin
                        ALUCtrl_o  <= dec_code;
                        ALUSrc_o   <= dec_src;
                        RegWrite_o <= dec_wr;
                        valid_o    <= 1'b1;
                        if (dec_mul && MUL_LAT > 1) begin
                            cnt    <= MUL_WAIT_INIT;
                            busy_o <= 1'b1;
                            state  <= MUL_WAIT;
                        end
                    end else if (valid_i) begin
                        valid_o    <= 1'b0;
                        RegWrite_o <= 1'b0;
                        illegal_o  <= 1'b1;
                    end else begin
                        valid_o    <= 1'b0;
                        RegWrite_o <= 1'b0;
                    end
                end
                MUL_WAIT: begin
                    // EX outputs stay frozen on the mul; the ID-side instruction is re-presented after busy drops.
                    if (flush_i) begin
                        cnt        <= '0;
                        busy_o     <= 1'b0;
                        valid_o    <= 1'b0;
                        RegWrite_o <= 1'b0;
                        state      <= RUN;
                    end else if (cnt == CNT_W'(1)) begin
                        cnt    <= '0;
                        busy_o <= 1'b0;
                        state  <= RUN;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                default: state <= RUN;
            endcase
        end
    end

    a_no_code7: assert property (@(posedge clk_i) disable iff (!rst_i) ALUCtrl_o != 3'b111);
    a_busy_in_wait: assert property (@(posedge clk_i) disable iff (!rst_i) busy_o == (state == MUL_WAIT));
    a_illegal_not_valid: assert property (@(posedge clk_i) disable iff (!rst_i) !(illegal_o && valid_o));

endmodule

// File: tb/tb_alu_ctrl_issue.sv
// Directed bench for alu_ctrl_issue with MUL_LAT = 3, 4 and 1 instances sharing one stimulus stream.
module tb_alu_ctrl_issue;

    logic       clk_i = 1'b0;
    logic       rst_i;
    logic       valid_i;
    logic [6:0] opcode_i;
    logic [2:0] funct3_i;
    logic [6:0] funct7_i;
    logic       stall_i;
    logic       flush_i;

    logic [2:0] ctrl3, ctrl4, ctrl1;
    logic       src3, src4, src1;
    logic       rw3, rw4, rw1;
    logic       vld3, vld4, vld1;
    logic       busy3, busy4, busy1;
    logic       ill3, ill4, ill1;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk_i = ~clk_i;

    alu_ctrl_issue #(.MUL_LAT(3), .CNT_W(4)) u_lat3 (
        .clk_i(clk_i), .rst_i(rst_i), .valid_i(valid_i), .opcode_i(opcode_i),
        .funct3_i(funct3_i), .funct7_i(funct7_i), .stall_i(stall_i), .flush_i(flush_i),
        .ALUCtrl_o(ctrl3), .ALUSrc_o(src3), .RegWrite_o(rw3), .valid_o(vld3),
        .busy_o(busy3), .illegal_o(ill3)
    );

    alu_ctrl_issue #(.MUL_LAT(4), .CNT_W(4)) u_lat4 (
        .clk_i(clk_i), .rst_i(rst_i), .valid_i(valid_i), .opcode_i(opcode_i),
        .funct3_i(funct3_i), .funct7_i(funct7_i), .stall_i(stall_i), .flush_i(flush_i),
        .ALUCtrl_o(ctrl4), .ALUSrc_o(src4), .RegWrite_o(rw4), .valid_o(vld4),
        .busy_o(busy4), .illegal_o(ill4)
    );

    alu_ctrl_issue #(.MUL_LAT(1), .CNT_W(4)) u_lat1 (
        .clk_i(clk_i), .rst_i(rst_i), .valid_i(valid_i), .opcode_i(opcode_i),
        .funct3_i(funct3_i), .funct7_i(funct7_i), .stall_i(stall_i), .flush_i(flush_i),
        .ALUCtrl_o(ctrl1), .ALUSrc_o(src1), .RegWrite_o(rw1), .valid_o(vld1),
        .busy_o(busy1), .illegal_o(ill1)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp)
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        else
            n_pass++;
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic present(input logic v, input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7);
        valid_i  = v;
        opcode_i = op;
        funct3_i = f3;
        funct7_i = f7;
    endtask

    // name, opcode, funct3, funct7, expected code, ALUSrc, RegWrite
    typedef struct {
        string      name;
        logic [6:0] op;
        logic [2:0] f3;
        logic [6:0] f7;
        logic [2:0] code;
        logic       src;
        logic       wr;
    } vec_t;

    vec_t vecs[10];

    initial begin
        vecs[0] = '{"add",  7'b0110011, 3'b000, 7'b0000000, 3'b101, 1'b0, 1'b1};
        vecs[1] = '{"sub",  7'b0110011, 3'b000, 7'b0100000, 3'b011, 1'b0, 1'b1};
        vecs[2] = '{"and",  7'b0110011, 3'b111, 7'b0000000, 3'b000, 1'b0, 1'b1};
        vecs[3] = '{"xor",  7'b0110011, 3'b100, 7'b0000000, 3'b001, 1'b0, 1'b1};
        vecs[4] = '{"sll",  7'b0110011, 3'b001, 7'b0000000, 3'b010, 1'b0, 1'b1};
        vecs[5] = '{"srai", 7'b0010011, 3'b101, 7'b0100000, 3'b110, 1'b1, 1'b1};
        vecs[6] = '{"addi", 7'b0010011, 3'b000, 7'b0000000, 3'b101, 1'b1, 1'b1};
        vecs[7] = '{"lw",   7'b0000011, 3'b010, 7'b0000000, 3'b101, 1'b1, 1'b1};
        vecs[8] = '{"sw",   7'b0100011, 3'b010, 7'b0000000, 3'b101, 1'b1, 1'b0};
        vecs[9] = '{"beq",  7'b1100011, 3'b000, 7'b0000000, 3'b011, 1'b0, 1'b0};

        rst_i   = 1'b0;
        stall_i = 1'b0;
        flush_i = 1'b0;
        present(1'b0, 7'd0, 3'd0, 7'd0);
        tick();
        tick();
        check("rst_ctrl", 32'(ctrl3), 32'h0);
        check("rst_valid", 32'(vld3), 32'h0);
        check("rst_busy", 32'(busy3), 32'h0);
        check("rst_regwrite", 32'(rw3), 32'h0);
        check("rst_illegal", 32'(ill3), 32'h0);
        #4 rst_i = 1'b1;

        // back-to-back decode of every supported non-mul instruction
        for (int i = 0; i < 10; i++) begin
            present(1'b1, vecs[i].op, vecs[i].f3, vecs[i].f7);
            tick();
            check({vecs[i].name, "_code"}, 32'(ctrl3), 32'(vecs[i].code));
            check({vecs[i].name, "_src"}, 32'(src3), 32'(vecs[i].src));
            check({vecs[i].name, "_wr"}, 32'(rw3), 32'(vecs[i].wr));
            check({vecs[i].name, "_valid"}, 32'(vld3), 32'h1);
        end

        present(1'b0, 7'd0, 3'd0, 7'd0);
        tick();
        check("bubble_valid", 32'(vld3), 32'h0);
        check("bubble_wr", 32'(rw3), 32'h0);
        check("bubble_code_hold", 32'(ctrl3), 32'h3);

        // mul then add held continuously, MUL_LAT=3
        present(1'b1, 7'b0110011, 3'b000, 7'b0000001);
        tick();
        check("mul3_e1_code", 32'(ctrl3), 32'h4);
        check("mul3_e1_busy", 32'(busy3), 32'h1);
        check("mul3_e1_valid", 32'(vld3), 32'h1);
        check("mul1_e1_code", 32'(ctrl1), 32'h4);
        check("mul1_e1_busy", 32'(busy1), 32'h0);
        present(1'b1, 7'b0110011, 3'b000, 7'b0000000);
        tick();
        check("mul3_e2_code", 32'(ctrl3), 32'h4);
        check("mul3_e2_busy", 32'(busy3), 32'h1);
        check("mul1_e2_code", 32'(ctrl1), 32'h5);
        check("mul1_e2_busy", 32'(busy1), 32'h0);
        tick();
        check("mul3_e3_code", 32'(ctrl3), 32'h4);
        check("mul3_e3_busy", 32'(busy3), 32'h0);
        tick();
        check("mul3_e4_code", 32'(ctrl3), 32'h5);
        check("mul3_e4_busy", 32'(busy3), 32'h0);
        check("mul4_e4_busy", 32'(busy4), 32'h0);
        check("mul4_e4_code_hold", 32'(ctrl4), 32'h4);

        present(1'b0, 7'd0, 3'd0, 7'd0);
        tick();

        // stall holds xor for two cycles, then sub enters
        present(1'b1, 7'b0110011, 3'b100, 7'b0000000);
        tick();
        check("stall_c0_code", 32'(ctrl3), 32'h1);
        present(1'b1, 7'b0110011, 3'b000, 7'b0100000);
        stall_i = 1'b1;
        tick();
        check("stall_c1_code", 32'(ctrl3), 32'h1);
        check("stall_c1_valid", 32'(vld3), 32'h1);
        tick();
        check("stall_c2_code", 32'(ctrl3), 32'h1);
        stall_i = 1'b0;
        tick();
        check("stall_release_code", 32'(ctrl3), 32'h3);

        // flush in the second MUL_WAIT cycle, MUL_LAT=4
        present(1'b1, 7'b0110011, 3'b000, 7'b0000001);
        tick();
        check("fl_e1_busy4", 32'(busy4), 32'h1);
        present(1'b1, 7'b0110011, 3'b000, 7'b0000000);
        tick();
        check("fl_e2_busy4", 32'(busy4), 32'h1);
        check("fl_e2_code4", 32'(ctrl4), 32'h4);
        flush_i = 1'b1;
        tick();
        check("fl_e3_valid4", 32'(vld4), 32'h0);
        check("fl_e3_wr4", 32'(rw4), 32'h0);
        check("fl_e3_busy4", 32'(busy4), 32'h0);
        check("fl_e3_code4_hold", 32'(ctrl4), 32'h4);
        flush_i = 1'b0;
        tick();
        check("fl_e4_code4", 32'(ctrl4), 32'h5);
        check("fl_e4_valid4", 32'(vld4), 32'h1);
        check("fl_e4_busy4", 32'(busy4), 32'h0);

        // illegal instructions pulse illegal_o and leave ALUCtrl alone
        present(1'b1, 7'b1111111, 3'b000, 7'b0000000);
        tick();
        check("ill_pulse", 32'(ill3), 32'h1);
        check("ill_valid", 32'(vld3), 32'h0);
        check("ill_wr", 32'(rw3), 32'h0);
        check("ill_code_hold", 32'(ctrl3), 32'h5);
        present(1'b1, 7'b0110011, 3'b000, 7'b0000010);
        tick();
        check("ill_rf7_pulse", 32'(ill3), 32'h1);
        present(1'b0, 7'd0, 3'd0, 7'd0);
        tick();
        check("ill_pulse_end", 32'(ill3), 32'h0);
        check("ill_end_code", 32'(ctrl3), 32'h5);

        // async reset between edges while in MUL_WAIT
        present(1'b1, 7'b0110011, 3'b000, 7'b0000001);
        tick();
        check("ar_busy_before", 32'(busy3), 32'h1);
        present(1'b0, 7'd0, 3'd0, 7'd0);
        #2 rst_i = 1'b0;
        #1;
        check("ar_busy3", 32'(busy3), 32'h0);
        check("ar_busy4", 32'(busy4), 32'h0);
        check("ar_ctrl3", 32'(ctrl3), 32'h0);
        check("ar_valid3", 32'(vld3), 32'h0);
        check("ar_wr3", 32'(rw3), 32'h0);
        #1 rst_i = 1'b1;

        present(1'b1, 7'b0110011, 3'b000, 7'b0000001);
        tick();
        check("lat1_mul_code", 32'(ctrl1), 32'h4);
        check("lat1_mul_busy", 32'(busy1), 32'h0);
        check("lat1_mul_valid", 32'(vld1), 32'h1);
        check("lat3_mul_busy_after_rst", 32'(busy3), 32'h1);
        present(1'b1, 7'b0110011, 3'b000, 7'b0000000);
        tick();
        check("lat1_next_code", 32'(ctrl1), 32'h5);
        check("lat1_next_busy", 32'(busy1), 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
